// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage:
// default sizing, the NOP encoding and the fetch-queue entry.
package if_stage_pkg;

  localparam int IfFqDepth = 2;
  localparam int IfMaxOutstanding = 2;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    logic        misaligned;
  } if_entry_t;

endpackage

// File: rtl/if_stage_sync_fifo.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, flush, count.
// A flush may coincide with a push; the pushed word becomes the only entry.
module if_stage_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 2,
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count == CW'(Depth));
  assign do_pop = pop && (count != '0) && !flush;
  // Push into a full FIFO is fine when a pop frees a slot this cycle.
  assign do_push = push && (flush || !full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= do_push ? bump('0) : '0;
      count <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop) rptr <= bump(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[flush ? '0 : wptr] <= din;
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns fetch PC, issues in-order imem word
// requests under a credit rule, queues responses and hands {pc, instr}
// to decode over valid/ready. Redirects flush the queue and discard
// in-flight responses.
// Ports: clk, rst (sync, active-high); imem_req_* / imem_rsp_* memory
// port; redirect_valid/redirect_pc; instr_valid/instr_ready, instr, pc,
// fetch_err, instr_misaligned toward decode.
// Option: define IF_MISALIGN_CHK_EN to halt on misaligned redirect
// targets and present a single flagged NOP entry.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter int FqDepth = IfFqDepth,
  parameter int MaxOutstanding = IfMaxOutstanding
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic        instr_misaligned
);

  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam int QW = $clog2(FqDepth + 1);
  localparam int EW = $bits(if_entry_t);

  logic [31:0]   fetch_pc;
  logic [31:0]   redirect_tgt;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [QW-1:0] q_count;
  logic          halted;
  logic          redirect_mis;
  logic          req_fire;
  logic          rsp_keep;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  if_entry_t     q_din;
  if_entry_t     q_head;

`ifdef IF_MISALIGN_CHK_EN
  assign redirect_mis = redirect_valid &&
                        (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= redirect_mis;
    end
  end
`else
  assign redirect_mis = 1'b0;
  assign halted = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Outstanding plus queued words never exceed the queue depth, so
  // every accepted request has a guaranteed slot for its response.
  assign imem_req_valid = !rst && !redirect_valid && !halted &&
    (int'(outstanding) < MaxOutstanding) &&
    ((int'(q_count) + int'(outstanding)) < FqDepth);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= ResetPc;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_tgt;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Everything still in flight at a redirect belongs to the old path;
  // a response landing in the redirect cycle is dropped directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard <= '0;
    end else if (redirect_valid) begin
      discard <= outstanding - OW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (discard != '0)) begin
      discard <= discard - OW'(1);
    end
  end

  // The in-flight PC FIFO occupancy is the outstanding count.
  if_stage_sync_fifo #(
    .Width(32),
    .Depth(MaxOutstanding)
  ) u_pc_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_fire),
    .din  (fetch_pc),
    .pop  (imem_rsp_valid),
    .flush(1'b0),
    .dout (rsp_pc),
    .count(outstanding)
  );

  assign rsp_keep = imem_rsp_valid && (discard == '0) &&
                    !redirect_valid;
  assign q_push = rsp_keep || redirect_mis;

  always_comb begin
    q_din = '0;
    if (redirect_mis) begin
      q_din.pc = redirect_pc;
      q_din.instr = NopInstr;
      q_din.misaligned = 1'b1;
    end else begin
      q_din.pc = rsp_pc;
      q_din.instr = imem_rsp_err ? NopInstr : imem_rsp_data;
      q_din.err = imem_rsp_err;
    end
  end

  if_stage_sync_fifo #(
    .Width(EW),
    .Depth(FqDepth)
  ) u_fetch_q (
    .clk  (clk),
    .rst  (rst),
    .push (q_push),
    .din  (q_din),
    .pop  (q_pop),
    .flush(redirect_valid),
    .dout (q_head),
    .count(q_count)
  );

  assign q_empty = (q_count == '0);
  assign instr_valid = !rst && !q_empty && !redirect_valid;
  assign q_pop = instr_valid && instr_ready;

  assign instr = instr_valid ? q_head.instr : '0;
  assign pc = instr_valid ? q_head.pc : '0;
  assign fetch_err = instr_valid && q_head.err;
  assign instr_misaligned = instr_valid && q_head.misaligned;

endmodule
